packet_flit_serializer: RTL and testbench

Packet injection stage between a traffic source (NI or traffic generator) and the router local input port. It accepts one packet descriptor plus a stream of payload words, emits a header flit built by `header_flit_generator`, then body and tail flits on the requested VC. Per-VC credit counters guarantee that no flit is written without a free downstream buffer slot.

---
 rtl/pronoc_pkg.sv | 23 ++
 rtl/header_flit_generator.sv | 35 +++
 rtl/pronoc_register.sv | 20 ++
 rtl/packet_flit_serializer.sv | 173 +++++++++++++++++
 tb/tb_packet_flit_serializer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pronoc_pkg.sv
// Shared NoC configuration constants, flit flag encodings and serializer state type.
// Only configuration 0 is defined; every width below belongs to it.
package pronoc_pkg;

  localparam int unsigned V       = 2;
  localparam int unsigned FPAYw   = 32;
  localparam int unsigned Fw      = FPAYw + V + 2;
  localparam int unsigned EAw     = 4;
  localparam int unsigned DAw     = 4;
  localparam int unsigned DSTPw   = 4;
  localparam int unsigned Cw      = 2;
  localparam int unsigned WEIGHTw = 4;
  localparam int unsigned BEw     = 4;
  localparam string       PCK_TYPE = "MULTI_FLIT";

  localparam logic [1:0] HDR_FLG    = 2'b10;
  localparam logic [1:0] BODY_FLG   = 2'b00;
  localparam logic [1:0] TAIL_FLG   = 2'b01;
  localparam logic [1:0] SINGLE_FLG = 2'b11;

  typedef enum logic {SER_IDLE, SER_BODY} ser_state_e;

endpackage

// File: rtl/header_flit_generator.sv
// Combinational header flit builder: packs routing fields LSB-first into the payload,
// places the one-hot VC above it and tags the flit with the header flag.
module header_flit_generator
  import pronoc_pkg::*;
#(
  parameter  int unsigned DATA_w = 0,
  localparam int unsigned HDATAw = (DATA_w > 0) ? DATA_w : 1
) (
  input  logic [EAw-1:0]     i_src_e_addr,
  input  logic [DAw-1:0]     i_dest_e_addr,
  input  logic [DSTPw-1:0]   i_destport,
  input  logic [Cw-1:0]      i_class,
  input  logic [WEIGHTw-1:0] i_weight,
  input  logic [BEw-1:0]     i_be,
  input  logic [HDATAw-1:0]  i_data,
  input  logic [V-1:0]       i_vc,
  output logic [Fw-1:0]      o_flit
);

  logic [FPAYw-1:0] w_payload;

  if (DATA_w > 0) begin : g_data
    assign w_payload = FPAYw'({i_data, i_be, i_weight, i_class, i_destport, i_dest_e_addr,
                               i_src_e_addr});
  end else begin : g_no_data
    // With no header data configured, the 1-bit data port is ignored.
    logic w_unused_data;
    assign w_unused_data = ^i_data;
    assign w_payload = FPAYw'({i_be, i_weight, i_class, i_destport, i_dest_e_addr,
                               i_src_e_addr});
  end

  assign o_flit = {HDR_FLG, i_vc, w_payload};

endmodule

// File: rtl/pronoc_register.sv
// Plain W-bit register with synchronous active-low clear to zero.
module pronoc_register #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!reset) r_q <= '0;
    else        r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/packet_flit_serializer.sv
// Packet injection stage: turns a descriptor plus payload stream into header/body/tail
// flits on one VC, gated by per-VC downstream credit counters.
module packet_flit_serializer
  import pronoc_pkg::*;
#(
  parameter  int unsigned NOC_ID       = 0,
  parameter  int unsigned DATA_w       = 0,
  parameter  int unsigned B            = 4,
  parameter  int unsigned MAX_PCK_SIZE = 16,
  localparam int unsigned SIZEw        = $clog2(MAX_PCK_SIZE + 1),
  localparam int unsigned HDATAw       = (DATA_w > 0) ? DATA_w : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pck_req_valid,
  output logic               pck_req_ready,
  input  logic [EAw-1:0]     src_e_addr,
  input  logic [DAw-1:0]     dest_e_addr,
  input  logic [DSTPw-1:0]   destport,
  input  logic [Cw-1:0]      class_in,
  input  logic [WEIGHTw-1:0] weight_in,
  input  logic [BEw-1:0]     be_in,
  input  logic [HDATAw-1:0]  hdr_data,
  input  logic [V-1:0]       vc_num,
  input  logic [SIZEw-1:0]   pck_size,
  input  logic               pay_valid,
  output logic               pay_ready,
  input  logic [FPAYw-1:0]   pay_data,
  input  logic [V-1:0]       credit_in,
  output logic [Fw-1:0]      flit_out,
  output logic               flit_out_wr,
  output logic               busy
);

  localparam int unsigned       CREDITw    = $clog2(B + 1);
  localparam logic [CREDITw-1:0] CreditMax  = CREDITw'(B);
  localparam logic [SIZEw-1:0]   SizeMax    = SIZEw'(MAX_PCK_SIZE);
  localparam logic [SIZEw-1:0]   SizeOne    = SIZEw'(1);
  localparam bit                 SingleOnly = (PCK_TYPE == "SINGLE_FLIT");

  ser_state_e                    r_state, w_state_next;
  logic [V-1:0]                  r_vc;
  logic [SIZEw-1:0]              r_remaining;
  logic [V-1:0][CREDITw-1:0]     r_credit, w_credit_next;
  logic [V-1:0]                  w_credit_nz, w_sel_vc, w_send_vec;
  logic                          w_can_send, w_accept, w_xfer, w_send, w_last;
  logic [SIZEw-1:0]              w_eff_size;
  logic [Fw-1:0]                 w_hdr_flit, w_flit_d;
  logic                          w_unused_noc_id;

  assign w_unused_noc_id = (NOC_ID != 0);

  header_flit_generator #(
    .DATA_w (DATA_w)
  ) u_hdr_gen (
    .i_src_e_addr  (src_e_addr),
    .i_dest_e_addr (dest_e_addr),
    .i_destport    (destport),
    .i_class       (class_in),
    .i_weight      (weight_in),
    .i_be          (be_in),
    .i_data        (hdr_data),
    .i_vc          (vc_num),
    .o_flit        (w_hdr_flit)
  );

  always_comb begin
    w_eff_size = pck_size;
    if (SingleOnly || pck_size == '0) w_eff_size = SizeOne;
    else if (pck_size > SizeMax)      w_eff_size = SizeMax;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= SER_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      SER_IDLE: if (w_accept && w_eff_size != SizeOne) w_state_next = SER_BODY;
      SER_BODY: if (w_xfer && w_last)                  w_state_next = SER_IDLE;
    endcase
  end

  // Output logic. A non-one-hot VC needs credit on every selected VC (none if zero).
  always_comb begin
    w_sel_vc   = (r_state == SER_IDLE) ? vc_num : r_vc;
    w_can_send = &(w_credit_nz | ~w_sel_vc);
    w_accept   = reset && (r_state == SER_IDLE) && pck_req_valid && w_can_send;
    w_xfer     = reset && (r_state == SER_BODY) && pay_valid && w_can_send;
    w_last     = (r_remaining == SizeOne);
    w_flit_d   = '0;
    if (w_accept) begin
      w_flit_d = w_hdr_flit;
      if (w_eff_size == SizeOne) w_flit_d[Fw-1 -: 2] = SINGLE_FLG;
    end else if (w_xfer) begin
      w_flit_d = {w_last ? TAIL_FLG : BODY_FLG, r_vc, pay_data};
    end
  end

  assign pck_req_ready = w_accept;
  assign pay_ready     = w_xfer;
  assign busy          = (r_state == SER_BODY);
  assign w_send        = w_accept | w_xfer;
  assign w_send_vec    = w_send ? w_sel_vc : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vc        <= '0;
      r_remaining <= '0;
    end else if (w_accept) begin
      r_vc        <= vc_num;
      r_remaining <= w_eff_size - SizeOne;
    end else if (w_xfer) begin
      r_remaining <= r_remaining - SizeOne;
    end
  end

  // A send and a returned credit in the same cycle cancel; increments saturate at B.
  for (genvar v = 0; v < V; v++) begin : g_credit
    assign w_credit_nz[v] = (r_credit[v] != '0);
    always_comb begin
      w_credit_next[v] = r_credit[v];
      if (w_send_vec[v] && !credit_in[v]) begin
        w_credit_next[v] = r_credit[v] - CREDITw'(1);
      end else if (!w_send_vec[v] && credit_in[v] && r_credit[v] != CreditMax) begin
        w_credit_next[v] = r_credit[v] + CREDITw'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_credit <= {V{CreditMax}};
    else        r_credit <= w_credit_next;
  end

  pronoc_register #(
    .W (Fw)
  ) u_flit_reg (
    .clk   (clk),
    .reset (reset),
    .i_d   (w_flit_d),
    .o_q   (flit_out)
  );

  pronoc_register #(
    .W (1)
  ) u_wr_reg (
    .clk   (clk),
    .reset (reset),
    .i_d   (w_send),
    .o_q   (flit_out_wr)
  );

`ifdef SIMULATION
  for (genvar v = 0; v < V; v++) begin : g_credit_chk
    always_ff @(posedge clk) begin
      if (reset && credit_in[v] && !w_send_vec[v] && r_credit[v] == CreditMax) begin
        $display("packet_flit_serializer: credit overflow on VC %0d", v);
        $finish;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !$onehot(vc_num)) $error("packet_flit_serializer: vc_num %b not one-hot", vc_num);
  end
`endif

endmodule

// File: tb/tb_packet_flit_serializer.sv
// Directed self-checking bench for packet_flit_serializer with V=2, B=4, MAX_PCK_SIZE=16.
module tb_packet_flit_serializer;
  import pronoc_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         pck_req_valid, pck_req_ready;
  logic [3:0]   src_e_addr, dest_e_addr, destport, weight_in, be_in;
  logic [1:0]   class_in;
  logic [0:0]   hdr_data;
  logic [1:0]   vc_num, credit_in;
  logic [4:0]   pck_size;
  logic         pay_valid, pay_ready;
  logic [31:0]  pay_data;
  logic [35:0]  flit_out;
  logic         flit_out_wr, busy;

  int n_vec = 0;
  int n_err = 0;

  // Header payload for src=1 dest=2 destport=3 class=1 weight=5 be=F, packed from bit 0 up.
  localparam logic [31:0] HdrPay = 32'h003D5321;

  packet_flit_serializer #(
    .NOC_ID       (0),
    .DATA_w       (0),
    .B            (4),
    .MAX_PCK_SIZE (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pck_req_valid (pck_req_valid),
    .pck_req_ready (pck_req_ready),
    .src_e_addr    (src_e_addr),
    .dest_e_addr   (dest_e_addr),
    .destport      (destport),
    .class_in      (class_in),
    .weight_in     (weight_in),
    .be_in         (be_in),
    .hdr_data      (hdr_data),
    .vc_num        (vc_num),
    .pck_size      (pck_size),
    .pay_valid     (pay_valid),
    .pay_ready     (pay_ready),
    .pay_data      (pay_data),
    .credit_in     (credit_in),
    .flit_out      (flit_out),
    .flit_out_wr   (flit_out_wr),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic return_credits(input logic [1:0] vec, input int n);
    repeat (n) begin
      @(negedge clk);
      credit_in = vec;
    end
    @(negedge clk);
    credit_in = 2'b00;
  endtask

  task automatic test_reset;
    reset = 1'b0; pck_req_valid = 1'b1; pay_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (pck_req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0", pck_req_ready); end
    n_vec++; if (pay_ready !== 1'b0) begin n_err++; $display("FAIL reset_pay_ready: got %b want 0", pay_ready); end
    n_vec++; if (flit_out_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr: got %b want 0", flit_out_wr); end
    n_vec++; if (flit_out !== 36'h0) begin n_err++; $display("FAIL reset_flit: got %h want 0", flit_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (dut.r_credit[0] !== 3'd4 || dut.r_credit[1] !== 3'd4) begin
      n_err++; $display("FAIL reset_credits: got %0d,%0d want 4,4", dut.r_credit[0], dut.r_credit[1]);
    end
    @(negedge clk);
    reset = 1'b1; pck_req_valid = 1'b0; pay_valid = 1'b0;
  endtask

  task automatic test_single;
    @(negedge clk);
    vc_num = 2'b01; pck_size = 5'd1; pck_req_valid = 1'b1;
    #1;
    n_vec++; if (pck_req_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", pck_req_ready); end
    @(posedge clk); #1;
    n_vec++; if (flit_out_wr !== 1'b1) begin n_err++; $display("FAIL single_wr: got %b want 1", flit_out_wr); end
    n_vec++; if (flit_out !== {2'b11, 2'b01, HdrPay}) begin
      n_err++; $display("FAIL single_flit: got %h want %h", flit_out, {2'b11, 2'b01, HdrPay});
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b want 0", busy); end
    n_vec++; if (dut.r_credit[0] !== 3'd3) begin n_err++; $display("FAIL single_credit: got %0d want 3", dut.r_credit[0]); end
    @(negedge clk);
    pck_req_valid = 1'b0; credit_in = 2'b01;
    @(posedge clk); #1;
    n_vec++; if (flit_out_wr !== 1'b0) begin n_err++; $display("FAIL single_idle_wr: got %b want 0", flit_out_wr); end
    n_vec++; if (dut.r_credit[0] !== 3'd4) begin n_err++; $display("FAIL single_credit_back: got %0d want 4", dut.r_credit[0]); end
    @(negedge clk);
    credit_in = 2'b00;
  endtask

  task automatic test_back_to_back;
    logic [1:0] flag;
    @(negedge clk);
    vc_num = 2'b10; pck_size = 5'd4; pck_req_valid = 1'b1;
    #1;
    n_vec++; if (pck_req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_req_ready: got %b want 1", pck_req_ready); end
    @(posedge clk); #1;
    n_vec++; if (flit_out !== {2'b10, 2'b10, HdrPay}) begin
      n_err++; $display("FAIL b2b_header: got %h want %h", flit_out, {2'b10, 2'b10, HdrPay});
    end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      // Request stays asserted: it must be ignored while a packet is in progress.
      pay_valid = 1'b1; pay_data = 32'hA + i;
      #1;
      n_vec++; if (pay_ready !== 1'b1) begin n_err++; $display("FAIL b2b_pay_ready%0d: got %b want 1", i, pay_ready); end
      n_vec++; if (pck_req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_req_blocked%0d: got %b want 0", i, pck_req_ready); end
      @(posedge clk); #1;
      flag = (i == 2) ? 2'b01 : 2'b00;
      n_vec++; if (flit_out_wr !== 1'b1 || flit_out !== {flag, 2'b10, 32'hA + i}) begin
        n_err++; $display("FAIL b2b_body%0d: got wr=%b %h want wr=1 %h", i, flit_out_wr, flit_out,
                          {flag, 2'b10, 32'hA + i});
      end
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_done_busy: got %b want 0", busy); end
    n_vec++; if (dut.r_credit[1] !== 3'd0) begin n_err++; $display("FAIL b2b_credit: got %0d want 0", dut.r_credit[1]); end
    @(negedge clk);
    pay_valid = 1'b0;
    #1;
    n_vec++; if (pck_req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_no_credit_req: got %b want 0", pck_req_ready); end
    @(posedge clk); #1;
    n_vec++; if (flit_out_wr !== 1'b0) begin n_err++; $display("FAIL b2b_no_credit_wr: got %b want 0", flit_out_wr); end
    @(negedge clk);
    pck_req_valid = 1'b0;
    return_credits(2'b10, 4);
  endtask

  task automatic test_credit_stall;
    @(negedge clk);
    vc_num = 2'b10; pck_size = 5'd6; pck_req_valid = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (flit_out[35:32] !== 4'b1010) begin n_err++; $display("FAIL stall_header: got %b want 1010", flit_out[35:32]); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pck_req_valid = 1'b0; pay_valid = 1'b1; pay_data = 32'h100 + i;
      @(posedge clk); #1;
      n_vec++; if (flit_out !== {2'b00, 2'b10, 32'h100 + i}) begin
        n_err++; $display("FAIL stall_body%0d: got %h want %h", i, flit_out, {2'b00, 2'b10, 32'h100 + i});
      end
    end
    @(negedge clk);
    pay_data = 32'h200;
    #1;
    n_vec++; if (pay_ready !== 1'b0) begin n_err++; $display("FAIL stall_pay_ready: got %b want 0", pay_ready); end
    @(posedge clk); #1;
    n_vec++; if (flit_out_wr !== 1'b0) begin n_err++; $display("FAIL stall_wr: got %b want 0", flit_out_wr); end
    @(negedge clk);
    credit_in = 2'b10;
    #1;
    n_vec++; if (pay_ready !== 1'b0) begin n_err++; $display("FAIL stall_same_cycle_credit: got %b want 0", pay_ready); end
    @(posedge clk); #1;
    n_vec++; if (dut.r_credit[1] !== 3'd1) begin n_err++; $display("FAIL stall_credit1: got %0d want 1", dut.r_credit[1]); end
    @(negedge clk);
    #1;
    n_vec++; if (pay_ready !== 1'b1) begin n_err++; $display("FAIL stall_resume: got %b want 1", pay_ready); end
    @(posedge clk); #1;
    n_vec++; if (flit_out !== {2'b00, 2'b10, 32'h200}) begin
      n_err++; $display("FAIL stall_body3: got %h want %h", flit_out, {2'b00, 2'b10, 32'h200});
    end
    n_vec++; if (dut.r_credit[1] !== 3'd1) begin n_err++; $display("FAIL simul_send_credit: got %0d want 1", dut.r_credit[1]); end
    @(negedge clk);
    credit_in = 2'b00; pay_data = 32'h201;
    @(posedge clk); #1;
    n_vec++; if (flit_out !== {2'b01, 2'b10, 32'h201}) begin
      n_err++; $display("FAIL stall_tail: got %h want %h", flit_out, {2'b01, 2'b10, 32'h201});
    end
    n_vec++; if (busy !== 1'b0 || dut.r_credit[1] !== 3'd0) begin
      n_err++; $display("FAIL stall_end: got busy=%b cr=%0d want busy=0 cr=0", busy, dut.r_credit[1]);
    end
    @(negedge clk);
    pay_valid = 1'b0;
    return_credits(2'b10, 4);
  endtask

  task automatic test_size_edges;
    logic exp_wr;
    @(negedge clk);
    vc_num = 2'b01; pck_size = 5'd0; pck_req_valid = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (flit_out_wr !== 1'b1 || flit_out[35:34] !== 2'b11) begin
      n_err++; $display("FAIL size0_flag: got wr=%b flag=%b want wr=1 flag=11", flit_out_wr, flit_out[35:34]);
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL size0_busy: got %b want 0", busy); end
    @(negedge clk);
    pck_req_valid = 1'b0;
    return_credits(2'b01, 1);
    // Size 20 clips to 16; a credit returns every sending cycle so the counter stays at 4.
    @(negedge clk);
    pck_size = 5'd20; pck_req_valid = 1'b1; credit_in = 2'b01;
    @(posedge clk); #1;
    n_vec++; if (flit_out[35:34] !== 2'b10) begin n_err++; $display("FAIL size20_header: got %b want 10", flit_out[35:34]); end
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      exp_wr = (i <= 14);
      pck_req_valid = 1'b0; pay_valid = 1'b1; pay_data = i;
      credit_in = exp_wr ? 2'b01 : 2'b00;
      @(posedge clk); #1;
      n_vec++; if (flit_out_wr !== exp_wr) begin
        n_err++; $display("FAIL size20_wr%0d: got %b want %b", i, flit_out_wr, exp_wr);
      end
      if (exp_wr) begin
        n_vec++; if (flit_out[35:34] !== ((i == 14) ? 2'b01 : 2'b00)) begin
          n_err++; $display("FAIL size20_flag%0d: got %b want %b", i, flit_out[35:34],
                            (i == 14) ? 2'b01 : 2'b00);
        end
      end
    end
    n_vec++; if (busy !== 1'b0 || dut.r_credit[0] !== 3'd4) begin
      n_err++; $display("FAIL size20_end: got busy=%b cr=%0d want busy=0 cr=4", busy, dut.r_credit[0]);
    end
    @(negedge clk);
    pay_valid = 1'b0; credit_in = 2'b00;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    vc_num = 2'b01; pck_size = 5'd5; pck_req_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    pck_req_valid = 1'b0; pay_valid = 1'b1; pay_data = 32'h11;
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b1 || dut.r_credit[0] !== 3'd2) begin
      n_err++; $display("FAIL rstmid_pre: got busy=%b cr=%0d want busy=1 cr=2", busy, dut.r_credit[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++; if (pay_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_pay_ready: got %b want 0", pay_ready); end
    @(posedge clk); #1;
    n_vec++; if (flit_out_wr !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_out: got wr=%b busy=%b want 0,0", flit_out_wr, busy);
    end
    n_vec++; if (dut.r_credit[0] !== 3'd4 || dut.r_credit[1] !== 3'd4) begin
      n_err++; $display("FAIL rstmid_credits: got %0d,%0d want 4,4", dut.r_credit[0], dut.r_credit[1]);
    end
    @(negedge clk);
    reset = 1'b1; pay_valid = 1'b0;
    vc_num = 2'b10; pck_size = 5'd1; pck_req_valid = 1'b1;
    #1;
    n_vec++; if (pck_req_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_new_ready: got %b want 1", pck_req_ready); end
    @(posedge clk); #1;
    n_vec++; if (flit_out_wr !== 1'b1 || flit_out[35:32] !== 4'b1110) begin
      n_err++; $display("FAIL rstmid_new_flit: got wr=%b top=%b want wr=1 top=1110", flit_out_wr, flit_out[35:32]);
    end
    @(negedge clk);
    pck_req_valid = 1'b0;
    return_credits(2'b10, 1);
  endtask

  task automatic test_single_stream;
    logic exp_acc;
    @(negedge clk);
    vc_num = 2'b01; pck_size = 5'd1; pck_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      exp_acc = (i < 4);
      #1;
      n_vec++; if (pck_req_ready !== exp_acc) begin
        n_err++; $display("FAIL stream_ready%0d: got %b want %b", i, pck_req_ready, exp_acc);
      end
      @(posedge clk); #1;
      n_vec++; if (flit_out_wr !== exp_acc) begin
        n_err++; $display("FAIL stream_wr%0d: got %b want %b", i, flit_out_wr, exp_acc);
      end
    end
    @(negedge clk);
    pck_req_valid = 1'b0;
    return_credits(2'b01, 4);
    n_vec++; if (dut.r_credit[0] !== 3'd4) begin n_err++; $display("FAIL stream_credit: got %0d want 4", dut.r_credit[0]); end
  endtask

  initial begin
    reset = 1'b0; pck_req_valid = 1'b0; pay_valid = 1'b0; credit_in = 2'b00;
    src_e_addr = 4'd1; dest_e_addr = 4'd2; destport = 4'd3; class_in = 2'd1;
    weight_in = 4'd5; be_in = 4'hF; hdr_data = 1'b1;
    vc_num = 2'b01; pck_size = 5'd1; pay_data = 32'h0;
    test_reset;
    test_single;
    test_back_to_back;
    test_credit_stall;
    test_size_edges;
    test_reset_mid;
    test_single_stream;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
